fifo_rd_stream_bridge: RTL and testbench

Read-side adapter between the synchronous `fifo` and a ready/valid consumer such as `ready_valid_skid_pipeline`. It pops words from the FIFO's `r_req`/`r_stall`/`r_data` port and presents them as a registered `B_valid`/`B_data`/`B_ready` stream. It prefetches into a 2-entry output buffer so the stream sustains one word per cycle despite the FIFO's one-cycle read latency. A synchronous `flush` discards buffered and in-flight words.

---
 rtl/fifo_rd_stream_bridge_if.sv | 30 +++
 rtl/fifo_rd_stream_bridge.sv | 79 +++++++
 tb/tb_fifo_rd_stream_bridge.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_bridge_if.sv
// Bundles the FIFO read port and the outgoing ready/valid stream of the bridge.
// Valid/ready: a word moves on a rising edge where B_valid and B_ready are both 1; B_valid never drops without that transfer or a flush.
interface fifo_rd_stream_bridge_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_r_req;
    logic                  fifo_r_stall;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  B_valid;
    logic [DATA_WIDTH-1:0] B_data;
    logic                  B_ready;

    modport master (
        output fifo_r_req,
        input  fifo_r_stall,
        input  fifo_r_data,
        output B_valid,
        output B_data,
        input  B_ready
    );

    modport slave (
        input  fifo_r_req,
        output fifo_r_stall,
        output fifo_r_data,
        input  B_valid,
        input  B_data,
        output B_ready
    );
endinterface

// File: rtl/fifo_rd_stream_bridge.sv
// Prefetching read adapter: pops a one-cycle-latency FIFO into a 2-entry buffer
// and presents the head word as a ready/valid stream.
module fifo_rd_stream_bridge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    fifo_rd_stream_bridge_if.master bus,
    output logic [1:0]              level
);
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;

    logic       pop;
    logic       issue;
    logic       capture;
    logic [1:0] after_pop;
    logic [2:0] occupancy;

    always_comb begin
        pop       = (count_q != 2'd0) & bus.B_ready & ~flush;
        after_pop = count_q - {1'b0, pop};
        occupancy = {1'b0, after_pop} + {2'b00, inflight_q};
        // Gated by reset_n so no pop request escapes while the bridge is held in reset.
        issue     = reset_n & ~flush & ~bus.fifo_r_stall & (occupancy <= 3'd1);
        capture   = inflight_q & ~flush;

        count_d    = after_pop;
        inflight_d = issue;
        e0_d       = e0_q;
        e1_d       = e1_q;

        if (pop && count_q == 2'd2) begin
            e0_d = e1_q;
        end

        // Returning word lands in the first slot free after this cycle's pop.
        if (capture) begin
            case (after_pop)
                2'd0: begin
                    e0_d    = bus.fifo_r_data;
                    count_d = 2'd1;
                end
                2'd1: begin
                    e1_d    = bus.fifo_r_data;
                    count_d = 2'd2;
                end
                default: ;
            endcase
        end

        if (flush) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            e0_q       <= '0;
            e1_q       <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
        end
    end

    assign bus.fifo_r_req = issue;
    assign bus.B_valid    = (count_q != 2'd0);
    assign bus.B_data     = e0_q;
    assign level          = count_q;
endmodule

// File: tb/tb_fifo_rd_stream_bridge.sv
// Directed bench for fifo_rd_stream_bridge with a behavioural FIFO and an
// expected-word queue checked on every stream transfer.
module tb_fifo_rd_stream_bridge;
    localparam int W = 32;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic [1:0] level;

    fifo_rd_stream_bridge_if #(.DATA_WIDTH(W)) bus ();

    fifo_rd_stream_bridge #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.master),
        .level   (level)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural FIFO ----------------
    logic [W-1:0] mem [0:63];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    int           req_cnt = 0;
    logic         tb_inflight;

    assign bus.fifo_r_stall = (wr_ptr == rd_ptr);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tb_inflight <= 1'b0;
        end else begin
            tb_inflight <= bus.fifo_r_req & ~bus.fifo_r_stall;
            if (bus.fifo_r_req && !bus.fifo_r_stall) begin
                bus.fifo_r_data <= mem[rd_ptr];
                rd_ptr          <= rd_ptr + 1;
                req_cnt         <= req_cnt + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d, input bit expect_out);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 1;
        if (expect_out) exp_q.push_back(d);
    endtask

    // Samples the stream at the falling edge, then returns 1 time unit after the next rising edge.
    task automatic tick();
        logic [W-1:0] e;
        @(negedge clk);
        if (reset_n) begin
            check_eq("no_req_while_stall", W'(bus.fifo_r_req & bus.fifo_r_stall), '0);
            check_eq("occupancy_le_2", W'(({1'b0, level} + {2'b00, tb_inflight}) <= 3'd2), 1);
            if (bus.B_valid && bus.B_ready && !flush) begin
                check_eq("sb_word_expected", W'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_order", bus.B_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.B_valid) && n < 60) begin
            tick();
            n++;
        end
        check_eq("drain_in_time", W'(n < 60), 1);
        check_eq("drain_queue_empty", W'(exp_q.size()), 0);
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] stream_tab [0:4];
    int base;

    initial begin
        stream_tab[0] = 32'd14;
        stream_tab[1] = 32'd18;
        stream_tab[2] = 32'd16;
        stream_tab[3] = 32'd20;
        stream_tab[4] = 32'd21;

        reset_n     = 1'b0;
        flush       = 1'b0;
        bus.B_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", W'(bus.B_valid), 0);
        check_eq("rst_data", bus.B_data, 0);
        check_eq("rst_level", W'(level), 0);

        // Single word; a FIFO word present during reset must not be requested.
        push_word(32'h0E, 1'b1);
        #1;
        check_eq("rst_no_req", W'(bus.fifo_r_req), 0);
        bus.B_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        #1;
        check_eq("single_req_t", W'(bus.fifo_r_req), 1);
        tick();
        check_eq("single_req_t1", W'(bus.fifo_r_req), 0);
        check_eq("single_valid_t1", W'(bus.B_valid), 0);
        tick();
        check_eq("single_valid_t2", W'(bus.B_valid), 1);
        check_eq("single_data_t2", bus.B_data, 32'h0E);
        tick();
        check_eq("single_valid_t3", W'(bus.B_valid), 0);
        check_eq("single_level_t3", W'(level), 0);

        // Streaming at one word per cycle.
        for (int i = 0; i < 5; i++) push_word(stream_tab[i], 1'b1);
        #1;
        check_eq("stream_req_t", W'(bus.fifo_r_req), 1);
        tick();
        check_eq("stream_req_t1", W'(bus.fifo_r_req), 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("stream_valid", W'(bus.B_valid), 1);
            check_eq("stream_data", bus.B_data, stream_tab[i]);
            tick();
        end
        check_eq("stream_done_valid", W'(bus.B_valid), 0);

        // Backpressure: only two words fetched, head held, then gapless drain.
        bus.B_ready = 1'b0;
        base = req_cnt;
        for (int i = 0; i < 8; i++) push_word(32'h30 + W'(i), 1'b1);
        repeat (10) tick();
        check_eq("bp_req_count", W'(req_cnt - base), 2);
        check_eq("bp_level", W'(level), 2);
        check_eq("bp_valid", W'(bus.B_valid), 1);
        check_eq("bp_head", bus.B_data, 32'h30);
        bus.B_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check_eq("bp_drain_valid", W'(bus.B_valid), 1);
            check_eq("bp_drain_data", bus.B_data, 32'h30 + W'(i));
            tick();
        end
        check_eq("bp_drain_level", W'(level), 0);

        // Empty gap between two words.
        push_word(32'd22, 1'b1);
        repeat (4) tick();
        push_word(32'd23, 1'b1);
        wait_drain();

        // Flush with one word buffered and one in flight; both are discarded.
        bus.B_ready = 1'b0;
        push_word(32'h50, 1'b0);
        push_word(32'h51, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (level == 2'd1) break;
        end
        check_eq("flush_pre_level", W'(level), 1);
        check_eq("flush_pre_inflight", W'(tb_inflight), 1);
        flush = 1'b1;
        #1;
        check_eq("flush_no_req", W'(bus.fifo_r_req), 0);
        tick();
        flush = 1'b0;
        check_eq("flush_valid", W'(bus.B_valid), 0);
        check_eq("flush_level", W'(level), 0);
        tick();
        check_eq("flush_stays_empty", W'(level), 0);
        bus.B_ready = 1'b1;
        push_word(32'h52, 1'b1);
        tick();
        tick();
        check_eq("post_flush_valid", W'(bus.B_valid), 1);
        check_eq("post_flush_data", bus.B_data, 32'h52);
        wait_drain();

        // Asynchronous reset while words are buffered.
        bus.B_ready = 1'b0;
        push_word(32'h40, 1'b1);
        push_word(32'h41, 1'b1);
        push_word(32'h42, 1'b1);
        repeat (4) tick();
        check_eq("rstmid_pre_valid", W'(bus.B_valid), 1);
        check_eq("rstmid_pre_level", W'(level), 2);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rstmid_valid", W'(bus.B_valid), 0);
        check_eq("rstmid_data", bus.B_data, 0);
        check_eq("rstmid_level", W'(level), 0);
        check_eq("rstmid_req", W'(bus.fifo_r_req), 0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        tick();
        reset_n     = 1'b1;
        bus.B_ready = 1'b1;
        #1;
        check_eq("rstmid_first_req", W'(bus.fifo_r_req), 1);
        tick();
        tick();
        check_eq("rstmid_resume_data", bus.B_data, 32'h42);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got %0d checks expected finish", n_checks);
        $fatal(1, "timeout");
    end
endmodule
